// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multi-cycle RV32I core
// Optional feature macro: MEM_WAIT_EN (FETCH/MEMREAD/MEMWRITE hold until mem_ready)
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   op[6:0], zero          opcode from IR, ALU zero flag
//   mem_ready              memory completes this cycle (MEM_WAIT_EN only)
//   pc_write, adr_src      PC enable, memory address select
//   mem_write, ir_write    memory write strobe, IR/old-PC enable
//   result_src[1:0]        result mux select
//   alu_src_a/b[1:0]       ALU operand selects
//   alu_op[1:0]            ALU operation class
//   reg_write              register file write enable
//   imm_src[2:0]           immediate format select
//   instr_done             pulse in the last cycle of each instruction
//   illegal_instr          pulse on an unsupported opcode
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic       illegal_instr
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER,
        EXECUTEI, JAL, LUI, ALUWB, BRANCH, ILLEGAL
    } state_t;
    state_t state, next;
    logic ready, pc_update, branch;
`ifdef MEM_WAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif
    always_ff @(posedge clk)
        state <= reset ? FETCH : next;
    always_comb begin
        next          = state;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        imm_src       = 3'b000;
        if (!reset) begin
            case (op)
                7'b0000011, 7'b0010011: imm_src = 3'b000;
                7'b0100011:             imm_src = 3'b001;
                7'b1100011:             imm_src = 3'b010;
                7'b1101111:             imm_src = 3'b011;
                7'b0110111:             imm_src = 3'b100;
                default:                imm_src = 3'b111;
            endcase
            case (state)
                FETCH: begin
                    ir_write   = ready;
                    pc_update  = ready;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    next       = ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (op)
                        7'b0000011, 7'b0100011: next = MEMADR;
                        7'b0110011:             next = EXECUTER;
                        7'b0010011:             next = EXECUTEI;
                        7'b1100011:             next = BRANCH;
                        7'b1101111:             next = JAL;
                        7'b0110111:             next = LUI;
                        default:                next = ILLEGAL;
                    endcase
                end
                MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    next      = op[5] ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    adr_src = 1'b1;
                    next    = ready ? MEMWB : MEMREAD;
                end
                MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next       = FETCH;
                end
                MEMWRITE: begin
                    adr_src    = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = ready;
                    next       = ready ? FETCH : MEMWRITE;
                end
                EXECUTER: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                    next      = ALUWB;
                end
                EXECUTEI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                    next      = ALUWB;
                end
                JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_update = 1'b1;
                    next      = ALUWB;
                end
                LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    next      = ALUWB;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next       = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 2'b10;
                    alu_op     = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                    next       = FETCH;
                end
                ILLEGAL: begin
                    illegal_instr = 1'b1;
                    instr_done    = 1'b1;
                    next          = FETCH;
                end
                default: next = FETCH;
            endcase
        end
    end
    // Branch decision uses the live zero flag so a taken branch loads the PC this cycle.
    assign pc_write = pc_update | (branch & zero);
endmodule
